cmp_sweep_driver: RTL and testbench
===================================

Name: cmp_sweep_driver

Overview:
- Hardware operand sequencer placed directly upstream of the 4-bit magnitude comparator.
- Drives every (p, q) operand pair into the comparator and samples its EQL/LTR outputs.
- Checks each result against an internal golden model and reports pass/fail, error count and first failing pair.
- Replaces the software sweep loop with an on-chip self-test that runs after reset or on demand.

Parameters:
WIDTH, 4, operand width of p and q; sweep covers 2^(2*WIDTH) pairs

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  pulse; begins sweep when idle or done
p_out  output  WIDTH  operand p to comparator
q_out  output  WIDTH  operand q to comparator
eql_in  input  1  comparator EQL (p == q)
ltr_in  input  1  comparator LTR (p < q, unsigned)
busy  output  1  high while sweep in progress
done  output  1  high from sweep completion until next start
pass  output  1  valid when done; 1 iff err_count == 0
err_count  output  2*WIDTH+1  number of mismatching pairs
fail_p  output  WIDTH  p of first mismatch; 0 if none
fail_q  output  WIDTH  q of first mismatch; 0 if none

Behaviour:
- One clock domain, clk. Reset is asynchronous and active-low (rst_n).
- Reset values:
  - state = IDLE.
  - p_out, q_out, err_count, fail_p, fail_q = 0.
  - busy, done, pass = 0.
- Reset asserted mid-sweep aborts immediately to these values. No partial results are retained.
- Operand counter {p_out, q_out}:
  - 2*WIDTH bits, p_out is the MSBs.
  - Increments by 1 per pair; q_out wraps into p_out exactly as in a concatenated add.
  - Sweep order is 00,01,…,0F,10,…,FF for WIDTH=4.
- FSM states: IDLE, DRIVE, SAMPLE, DONE.
- IDLE:
  - busy=0, done=0.
  - On start=1: clear err_count, fail_p, fail_q, and the operand counter; go to DRIVE.
- DRIVE:
  - busy=1. Operands are stable on p_out/q_out for this whole cycle, giving the combinational comparator settle time.
  - Always go to SAMPLE next.
- SAMPLE: busy=1. At the clock edge ending this cycle:
  - Expected values: exp_eql = (p_out == q_out) and exp_ltr = (p_out < q_out), unsigned.
  - Mismatch: eql_in != exp_eql OR ltr_in != exp_ltr. This includes the illegal case eql_in=ltr_in=1.
  - On a mismatch, err_count increments. If this is the first mismatch of the sweep, fail_p/fail_q capture the current operands.
  - If {p_out,q_out} is all-ones: go to DONE; the operand counter holds.
  - Otherwise: increment the operand counter and go to DRIVE.
- DONE:
  - busy=0, done=1, pass = (err_count == 0).
  - Results hold until start=1, which behaves exactly as start in IDLE.
- pass is 0 in every state other than DONE.
- Timing:
  - 2 cycles per pair; 2^(2*WIDTH+1) cycles per sweep.
  - For WIDTH=4, done rises 512 clocks after the edge that samples start.
- start while busy is ignored.
- err_count never saturates: its width holds the maximum, 2^(2*WIDTH).
- eql_in/ltr_in are ignored outside SAMPLE.

Optional Feature:
- Macro: CMP_SWEEP_STOP_ON_FAIL_EN
- Defined: the first mismatch in SAMPLE ends the sweep and goes to DONE.
  - err_count = 1.
  - fail_p/fail_q hold the failing pair.
  - p_out/q_out hold the failing operands.
- Undefined: the full sweep always completes and counts all mismatches.
- Fault-free behaviour is identical in both builds.

Test Plan:
- Golden comparator connected, pulse start → busy for 512 cycles, then done=1, pass=1, err_count=0, fail_p=fail_q=0, p_out=q_out=F.
- ltr_in stuck at 0 → done after 512 cycles, pass=0, err_count=120, fail_p=0, fail_q=1.
- eql_in inverted, ltr_in from golden model → err_count=256, fail_p=0, fail_q=0, pass=0.
- rst_n pulled low after 100 cycles of a sweep, released, start pulsed again with golden comparator:
  - All outputs return to 0 asynchronously.
  - The new sweep starts at pair 00 and finishes with err_count=0.
- start held high during a sweep, and pulsed again in DONE:
  - No restart mid-sweep.
  - The second start clears results and reruns a full 512-cycle sweep.
- Build with CMP_SWEEP_STOP_ON_FAIL_EN and ltr_in stuck 0 → done 4 cycles after start, err_count=1, fail_p=0, fail_q=1, p_out=0, q_out=1.

Source files
------------

// File: rtl/cmp_sweep_driver.sv
// cmp_sweep_driver
// On-chip self-test sequencer for a WIDTH-bit magnitude comparator.
// It drives every (p, q) operand pair into the comparator and samples the
// EQL/LTR results. Each result is checked against a built-in golden model.
// Reported results are pass/fail, a mismatch count and the first failing pair.
//
// Each pair takes two cycles. In DRIVE the operands settle through the
// comparator. In SAMPLE the result is checked at the closing clock edge.
// A full sweep therefore takes 2^(2*WIDTH+1) cycles.
//
// Optional build macro: CMP_SWEEP_STOP_ON_FAIL_EN
//   Defined   : the first mismatch ends the sweep. The failing operands stay
//               on p_out/q_out and err_count reads 1.
//   Undefined : the full sweep always runs and every mismatch is counted.
// Fault-free behaviour is identical in both builds.

module cmp_sweep_driver #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [WIDTH-1:0]     p_out,
    output logic [WIDTH-1:0]     q_out,
    input  logic                 eql_in,
    input  logic                 ltr_in,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2*WIDTH:0]     err_count,
    output logic [WIDTH-1:0]     fail_p,
    output logic [WIDTH-1:0]     fail_q
);

    // Operand counter width ({p, q}) and error counter width.
    // The error counter is one bit wider so it can hold 2^(2*WIDTH) without saturating.
    localparam int CW = 2 * WIDTH;
    localparam int EW = CW + 1;

    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [EW-1:0] ERR_ONE  = EW'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Golden comparator: a mismatch occurs if either output disagrees with the expected relation.
    // This also flags the illegal case where EQL and LTR are both high.
    function automatic logic cmp_mismatch(
        input logic [WIDTH-1:0] p,
        input logic [WIDTH-1:0] q,
        input logic             eql,
        input logic             ltr
    );
        logic exp_eql;
        logic exp_ltr;
        exp_eql = (p == q);
        exp_ltr = (p < q);
        return (eql != exp_eql) || (ltr != exp_ltr);
    endfunction

    // Sweep-end detection: the last pair is the all-ones operand word.
    function automatic logic is_last_pair(input logic [CW-1:0] cnt);
        return (cnt == {CW{1'b1}});
    endfunction

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [EW-1:0]     err_q, err_d;
    logic [WIDTH-1:0]  fail_p_q, fail_p_d;
    logic [WIDTH-1:0]  fail_q_q, fail_q_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic              mismatch_s;
    logic [WIDTH-1:0]  cur_p_s;
    logic [WIDTH-1:0]  cur_q_s;

    // Split the operand counter: p is the upper half and q is the lower half.
    // Therefore q wraps into p as in a concatenated add.
    assign cur_p_s = cnt_q[CW-1:WIDTH];
    assign cur_q_s = cnt_q[WIDTH-1:0];

    // Next-state, counter and result update logic for the sweep FSM.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        fail_p_d   = fail_p_q;
        fail_q_d   = fail_q_q;
        mismatch_s = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    cnt_d    = '0;
                    err_d    = '0;
                    fail_p_d = '0;
                    fail_q_d = '0;
                    state_d  = ST_DRIVE;
                end else begin
                    state_d  = state_q;
                end
            end

            ST_DRIVE: begin
                // Operands are held for a full cycle so the comparator can settle.
                state_d = ST_SAMPLE;
            end

            ST_SAMPLE: begin
                mismatch_s = cmp_mismatch(cur_p_s, cur_q_s, eql_in, ltr_in);
                if (mismatch_s) begin
                    err_d = err_q + ERR_ONE;
                    if (err_q == '0) begin
                        fail_p_d = cur_p_s;
                        fail_q_d = cur_q_s;
                    end else begin
                        fail_p_d = fail_p_q;
                        fail_q_d = fail_q_q;
                    end
                end else begin
                    err_d = err_q;
                end

`ifdef CMP_SWEEP_STOP_ON_FAIL_EN
                // Leave the failing operands on the outputs for debug.
                if (mismatch_s) begin
                    state_d = ST_DONE;
                end else if (is_last_pair(cnt_q)) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                    state_d = ST_DRIVE;
                end
`else
                if (is_last_pair(cnt_q)) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                    state_d = ST_DRIVE;
                end
`endif
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Status flags are derived from the next state so they are registered alongside it.
    always_comb begin
        busy_d = (state_d == ST_DRIVE) || (state_d == ST_SAMPLE);
        done_d = (state_d == ST_DONE);
        if (state_d == ST_DONE) begin
            pass_d = (err_d == '0);
        end else begin
            pass_d = 1'b0;
        end
    end

    // State and result registers; asynchronous reset discards any partial sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            err_q    <= '0;
            fail_p_q <= '0;
            fail_q_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            fail_p_q <= fail_p_d;
            fail_q_q <= fail_q_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
        end
    end

    assign p_out     = cur_p_s;
    assign q_out     = cur_q_s;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_p    = fail_p_q;
    assign fail_q    = fail_q_q;

endmodule

// File: tb/tb_cmp_sweep_driver.sv
// Directed testbench for cmp_sweep_driver (WIDTH = 4).
// A behavioural comparator with selectable faults feeds eql_in/ltr_in.
// Expected counts and pairs below are hand-derived:
//   - ltr stuck at 0 misses every p<q pair, which is 120 of 256 pairs.
//     The first such pair is (0,1).
//   - An inverted eql output fails all 256 pairs. The first such pair is (0,0).
module tb_cmp_sweep_driver;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] p_out;
    logic [3:0] q_out;
    logic       eql_in;
    logic       ltr_in;
    logic       busy;
    logic       done;
    logic       pass;
    logic [8:0] err_count;
    logic [3:0] fail_p;
    logic [3:0] fail_q;

    int n_tests;
    int n_fail;
    int mode;   // 0 golden, 1 ltr stuck at 0, 2 eql inverted

    cmp_sweep_driver #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .p_out     (p_out),
        .q_out     (q_out),
        .eql_in    (eql_in),
        .ltr_in    (ltr_in),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .fail_p    (fail_p),
        .fail_q    (fail_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural comparator under test, with injectable faults.
    always_comb begin
        eql_in = (p_out == q_out);
        ltr_in = (p_out < q_out);
        case (mode)
            1: ltr_in = 1'b0;
            2: eql_in = ~(p_out == q_out);
            default: ;
        endcase
    end

    // Pulse start across one rising edge; returns at the falling edge after that edge.
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Count falling edges until done is high, up to a fixed bound.
    // It also counts cycles where busy was unexpectedly low.
    task automatic wait_done(output int cycles, output int busy_low);
        cycles   = 0;
        busy_low = 0;
        while (!done && cycles < 2000) begin
            if (!busy) busy_low++;
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        mode  = 0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({p_out, q_out, busy, done, pass, err_count, fail_p, fail_q} !== 28'd0) begin
            n_fail++;
            $display("FAIL reset_values: got p=%h q=%h busy=%b done=%b pass=%b err=%0d fp=%h fq=%h, want all 0",
                     p_out, q_out, busy, done, pass, err_count, fail_p, fail_q);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_golden_sweep();
        int cyc;
        int bl;
        mode = 0;
        pulse_start();
        n_tests++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL golden_busy_start: busy=%b done=%b, want 1 0", busy, done);
        end
        wait_done(cyc, bl);
        n_tests++;
        if (cyc != 512 || bl != 0) begin
            n_fail++;
            $display("FAIL golden_latency: cycles=%0d busy_low=%0d, want 512 0", cyc, bl);
        end
        n_tests++;
        if (pass !== 1'b1 || busy !== 1'b0 || err_count !== 9'd0 || fail_p !== 4'd0 || fail_q !== 4'd0
            || p_out !== 4'hF || q_out !== 4'hF) begin
            n_fail++;
            $display("FAIL golden_result: pass=%b busy=%b err=%0d fp=%h fq=%h p=%h q=%h, want 1 0 0 0 0 F F",
                     pass, busy, err_count, fail_p, fail_q, p_out, q_out);
        end
    endtask

`ifndef CMP_SWEEP_STOP_ON_FAIL_EN
    task automatic test_ltr_stuck();
        int cyc;
        int bl;
        mode = 1;
        pulse_start();
        wait_done(cyc, bl);
        n_tests++;
        if (cyc != 512) begin
            n_fail++;
            $display("FAIL ltr_stuck_latency: cycles=%0d, want 512", cyc);
        end
        n_tests++;
        if (pass !== 1'b0 || err_count !== 9'd120 || fail_p !== 4'd0 || fail_q !== 4'd1) begin
            n_fail++;
            $display("FAIL ltr_stuck_result: pass=%b err=%0d fp=%h fq=%h, want 0 120 0 1",
                     pass, err_count, fail_p, fail_q);
        end
    endtask

    task automatic test_eql_inverted();
        int cyc;
        int bl;
        mode = 2;
        pulse_start();
        wait_done(cyc, bl);
        n_tests++;
        if (cyc != 512 || pass !== 1'b0 || err_count !== 9'd256 || fail_p !== 4'd0 || fail_q !== 4'd0) begin
            n_fail++;
            $display("FAIL eql_inverted: cycles=%0d pass=%b err=%0d fp=%h fq=%h, want 512 0 256 0 0",
                     cyc, pass, err_count, fail_p, fail_q);
        end
    endtask
`else
    task automatic test_stop_on_fail();
        int cyc;
        int bl;
        mode = 1;
        pulse_start();
        wait_done(cyc, bl);
        n_tests++;
        if (cyc != 4 || pass !== 1'b0 || err_count !== 9'd1 || fail_p !== 4'd0 || fail_q !== 4'd1
            || p_out !== 4'd0 || q_out !== 4'd1) begin
            n_fail++;
            $display("FAIL stop_on_fail: cycles=%0d pass=%b err=%0d fp=%h fq=%h p=%h q=%h, want 4 0 1 0 1 0 1",
                     cyc, pass, err_count, fail_p, fail_q, p_out, q_out);
        end
    endtask
`endif

    task automatic test_reset_midsweep();
        int cyc;
        int bl;
        mode = 1;
        pulse_start();
        repeat (100) @(negedge clk);
        // Counter advances on every second edge, so pair 50 = 0x32 is on the bus.
        n_tests++;
        if (p_out !== 4'h3 || q_out !== 4'h2 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midsweep_pair: p=%h q=%h busy=%b, want 3 2 1", p_out, q_out, busy);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({p_out, q_out, busy, done, pass, err_count, fail_p, fail_q} !== 28'd0) begin
            n_fail++;
            $display("FAIL async_reset: p=%h q=%h busy=%b done=%b pass=%b err=%0d fp=%h fq=%h, want all 0",
                     p_out, q_out, busy, done, pass, err_count, fail_p, fail_q);
        end
        @(negedge clk);
        rst_n = 1'b1;
        mode  = 0;
        pulse_start();
        n_tests++;
        if (p_out !== 4'h0 || q_out !== 4'h0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_pair0: p=%h q=%h busy=%b, want 0 0 1", p_out, q_out, busy);
        end
        wait_done(cyc, bl);
        n_tests++;
        if (cyc != 512 || err_count !== 9'd0 || pass !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_result: cycles=%0d err=%0d pass=%b, want 512 0 1", cyc, err_count, pass);
        end
    endtask

    task automatic test_start_held();
        int cyc;
        mode = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        cyc = 0;
        // Hold start high for 300 cycles; it must not restart the sweep.
        while (cyc < 300 && !done) begin
            @(negedge clk);
            cyc++;
        end
        n_tests++;
        if (p_out !== 4'h9 || q_out !== 4'h6) begin
            n_fail++;
            $display("FAIL start_held_no_restart: p=%h q=%h, want 9 6", p_out, q_out);
        end
        start = 1'b0;
        while (!done && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        n_tests++;
        if (cyc != 512 || pass !== 1'b1) begin
            n_fail++;
            $display("FAIL start_held_latency: cycles=%0d pass=%b, want 512 1", cyc, pass);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        int bl;
        mode = 1;
        pulse_start();
        wait_done(cyc, bl);
        n_tests++;
        if (done !== 1'b1 || pass !== 1'b0 || fail_q !== 4'd1) begin
            n_fail++;
            $display("FAIL b2b_faulty_run: done=%b pass=%b fq=%h, want 1 0 1", done, pass, fail_q);
        end
        mode = 0;
        pulse_start();
        n_tests++;
        if (done !== 1'b0 || busy !== 1'b1 || pass !== 1'b0 || err_count !== 9'd0
            || fail_p !== 4'd0 || fail_q !== 4'd0) begin
            n_fail++;
            $display("FAIL b2b_clear: done=%b busy=%b pass=%b err=%0d fp=%h fq=%h, want 0 1 0 0 0 0",
                     done, busy, pass, err_count, fail_p, fail_q);
        end
        wait_done(cyc, bl);
        n_tests++;
        if (cyc != 512 || pass !== 1'b1 || err_count !== 9'd0) begin
            n_fail++;
            $display("FAIL b2b_rerun: cycles=%0d pass=%b err=%0d, want 512 1 0", cyc, pass, err_count);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        start   = 1'b0;
        mode    = 0;
        test_reset();
        test_golden_sweep();
`ifndef CMP_SWEEP_STOP_ON_FAIL_EN
        test_ltr_stuck();
        test_eql_inverted();
`else
        test_stop_on_fail();
`endif
        test_reset_midsweep();
        test_start_held();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
